// File: rtl/mem_port_arbiter_if.sv
// Memory port bundle: fetch side, data side and the single-port memory.
// slave = arbiter view, master = pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                if_req_i;
  logic [ADDR_W-1:0]   if_addr_i;
  logic                if_gnt_o;
  logic                if_rvalid_o;
  logic [DATA_W-1:0]   if_rdata_o;

  logic                d_req_i;
  logic                d_we_i;
  logic [ADDR_W-1:0]   d_addr_i;
  logic [DATA_W-1:0]   d_wdata_i;
  logic [DATA_W/8-1:0] d_be_i;
  logic                d_gnt_o;
  logic                d_rvalid_o;
  logic [DATA_W-1:0]   d_rdata_o;

  logic                mem_en_o;
  logic                mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W/8-1:0] mem_be_o;
  logic [DATA_W-1:0]   mem_rdata_i;
  logic                busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i,
    input  d_wdata_i, d_be_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o,
    output mem_wdata_o, mem_be_o, busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i,
    output d_wdata_i, d_be_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o,
    input  mem_wdata_o, mem_be_o, busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and load/store.
// Data side wins by default; a streak counter lets fetch through.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = (MEM_LATENCY > 1) ?
                         $clog2(MEM_LATENCY) : 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_lat_cnt;
  logic [CNT_W-1:0] w_lat_nxt;
  logic             r_own_d;
  logic             w_own_d_nxt;
  logic             r_own_we;
  logic             w_own_we_nxt;
  logic [SW-1:0]    r_starve;
  logic [SW-1:0]    w_starve_nxt;

  logic w_resp;
  logic w_window;
  logic w_force_if;
  logic w_gnt_d;
  logic w_gnt_if;

  // Response cycle doubles as the next issue slot.
  assign w_resp     = !rst && (r_state == WAIT)
                      && (r_lat_cnt == '0);
  assign w_window   = !rst && ((r_state == IDLE) || w_resp);
  assign w_force_if = bus.if_req_i
                      && (r_starve == SW'(STARVE_LIMIT));
  assign w_gnt_d    = w_window && bus.d_req_i && !w_force_if;
  assign w_gnt_if   = w_window && bus.if_req_i && !w_gnt_d;

  always_comb begin
    w_state_nxt      = r_state;
    w_lat_nxt        = r_lat_cnt;
    w_own_d_nxt      = r_own_d;
    w_own_we_nxt     = r_own_we;
    w_starve_nxt     = r_starve;
    bus.if_gnt_o     = 1'b0;
    bus.if_rvalid_o  = 1'b0;
    bus.if_rdata_o   = '0;
    bus.d_gnt_o      = 1'b0;
    bus.d_rvalid_o   = 1'b0;
    bus.d_rdata_o    = '0;
    bus.mem_en_o     = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_wdata_o  = '0;
    bus.mem_be_o     = '0;
    bus.busy_o       = !rst && (r_state == WAIT);

    if (r_state == WAIT && r_lat_cnt != '0)
      w_lat_nxt = r_lat_cnt - CNT_W'(1);

    if (w_resp) begin
      w_state_nxt = IDLE;
      if (r_own_d) begin
        bus.d_rvalid_o = 1'b1;
        bus.d_rdata_o  = r_own_we ? '0 : bus.mem_rdata_i;
      end else begin
        bus.if_rvalid_o = 1'b1;
        bus.if_rdata_o  = bus.mem_rdata_i;
      end
    end

    unique case (1'b1)
      w_gnt_d: begin
        bus.d_gnt_o     = 1'b1;
        bus.mem_en_o    = 1'b1;
        bus.mem_we_o    = bus.d_we_i;
        bus.mem_addr_o  = bus.d_addr_i;
        bus.mem_wdata_o = bus.d_wdata_i;
        bus.mem_be_o    = bus.d_be_i;
        w_state_nxt     = WAIT;
        w_lat_nxt       = CNT_W'(MEM_LATENCY - 1);
        w_own_d_nxt     = 1'b1;
        w_own_we_nxt    = bus.d_we_i;
        if (!bus.if_req_i)
          w_starve_nxt = '0;
        else if (r_starve != SW'(STARVE_LIMIT))
          w_starve_nxt = r_starve + SW'(1);
      end
      w_gnt_if: begin
        bus.if_gnt_o   = 1'b1;
        bus.mem_en_o   = 1'b1;
        bus.mem_addr_o = bus.if_addr_i;
        bus.mem_be_o   = '1;
        w_state_nxt    = WAIT;
        w_lat_nxt      = CNT_W'(MEM_LATENCY - 1);
        w_own_d_nxt    = 1'b0;
        w_own_we_nxt   = 1'b0;
        w_starve_nxt   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_own_d   <= 1'b0;
      r_own_we  <= 1'b0;
      r_starve  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      r_own_d   <= w_own_d_nxt;
      r_own_we  <= w_own_we_nxt;
      r_starve  <= w_starve_nxt;
    end
  end
endmodule
